ibex_rf_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters, EX (ALU/MUL) and LSU (load data), using round-robin arbitration and a registered write-port drive. Also keeps a pending-write scoreboard: issue logic reserves a destination register, and the matching writeback releases it. Read-address hazard flags from the scoreboard feed the ID-stage stall logic. Sits between the EX/LSU writeback paths and the latch/FF register file.

---
 rtl/ibex_pkg.sv | 15 +
 rtl/ibex_rf_scoreboard.sv | 52 +++++
 rtl/ibex_rf_wb_arbiter.sv | 105 ++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types and constants for the register-file writeback path.
package ibex_pkg;

  localparam int unsigned RF_ADDR_W = 5;

  typedef enum logic {
    WB_SRC_EX  = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  function automatic int unsigned rf_addr_width(input bit rv32e);
    return rv32e ? 4 : 5;
  endfunction

endpackage

// File: rtl/ibex_rf_scoreboard.sv
// Pending-write bitmap: issue reserves a destination, writeback releases it,
// and the ID stage looks up read-address hazards.
module ibex_rf_scoreboard #(
  parameter int unsigned AddrW = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [AddrW-1:0] set_addr_i,
  input  logic             clr_i,
  input  logic [AddrW-1:0] clr_addr_i,
  input  logic             flush_i,
  input  logic [AddrW-1:0] raddr_a_i,
  input  logic [AddrW-1:0] raddr_b_i,
  output logic             hazard_a_o,
  output logic             hazard_b_o,
  output logic             err_o
);

  localparam int unsigned NumWords = 1 << AddrW;

  logic [NumWords-1:0] pending_q, pending_d;
  logic                err_q, err_d;
  logic                set_ok, clr_ok;

  // Clear before set so a same-cycle reserve wins; flush overrides both.
  always_comb begin
    set_ok    = set_i & (set_addr_i != '0);
    clr_ok    = clr_i & (clr_addr_i != '0);
    pending_d = pending_q;
    err_d     = err_q | (set_ok & pending_q[set_addr_i]);
    if (clr_ok) pending_d[clr_addr_i] = 1'b0;
    if (set_ok) pending_d[set_addr_i] = 1'b1;
    if (flush_i) pending_d = '0;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign hazard_a_o = pending_q[raddr_a_i];
  assign hazard_b_o = pending_q[raddr_b_i];
  assign err_o      = err_q;

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Round-robin arbiter sharing the RF write port between EX and LSU writeback,
// with a registered write-port drive and a pending-write scoreboard.
module ibex_rf_wb_arbiter
  import ibex_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_addr_i,
  input  logic [DataWidth-1:0] ex_data_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_data_i,
  output logic                 lsu_ready_o,
  input  logic                 reserve_i,
  input  logic [4:0]           reserve_addr_i,
  input  logic                 flush_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 err_o
);

  localparam int unsigned AddrW = rf_addr_width(RV32E);

  wb_src_e                last_grant_q, last_grant_d;
  logic                   rf_we_q, rf_we_d;
  logic [RF_ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0]   rf_wdata_q, rf_wdata_d;

  logic                   ex_gnt, lsu_gnt, wb_hs, wb_write;
  logic [AddrW-1:0]       wb_addr;
  logic [DataWidth-1:0]   wb_data;

  // On a tie the requester not granted last time wins.
  always_comb begin
    ex_gnt   = ex_valid_i & (~lsu_valid_i | (last_grant_q == WB_SRC_LSU));
    lsu_gnt  = lsu_valid_i & ~ex_gnt;
    wb_hs    = ex_gnt | lsu_gnt;
    wb_addr  = ex_gnt ? ex_addr_i[AddrW-1:0] : lsu_addr_i[AddrW-1:0];
    wb_data  = ex_gnt ? ex_data_i : lsu_data_i;
    wb_write = wb_hs & (wb_addr != '0);

    last_grant_d = last_grant_q;
    if (ex_gnt) begin
      last_grant_d = WB_SRC_EX;
    end else if (lsu_gnt) begin
      last_grant_d = WB_SRC_LSU;
    end

    rf_we_d    = wb_write;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_write) begin
      rf_waddr_d = RF_ADDR_W'(wb_addr);
      rf_wdata_d = wb_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= WB_SRC_LSU;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign ex_ready_o  = ex_gnt;
  assign lsu_ready_o = lsu_gnt;
  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;

  ibex_rf_scoreboard #(
    .AddrW (AddrW)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (reserve_i),
    .set_addr_i (reserve_addr_i[AddrW-1:0]),
    .clr_i      (wb_hs),
    .clr_addr_i (wb_addr),
    .flush_i    (flush_i),
    .raddr_a_i  (raddr_a_i[AddrW-1:0]),
    .raddr_b_i  (raddr_b_i[AddrW-1:0]),
    .hazard_a_o (hazard_a_o),
    .hazard_b_o (hazard_b_o),
    .err_o      (err_o)
  );

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Self-checking bench for ibex_rf_wb_arbiter: directed scenarios plus a
// randomized run against a behavioural model of arbitration and scoreboard.
module tb_ibex_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, lsu_valid, reserve, flush;
  logic [4:0]  ex_addr, lsu_addr, reserve_addr, raddr_a, raddr_b;
  logic [31:0] ex_data, lsu_data;

  logic        ex_ready, lsu_ready, hazard_a, hazard_b, rf_we, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        e_ex_ready, e_lsu_ready, e_hazard_a, e_hazard_b, e_rf_we, e_err;
  logic [4:0]  e_rf_waddr;
  logic [31:0] e_rf_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state
  bit          m_last_ex;
  bit          m_gex;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_err;
  bit          m_pend [32];

  always #5 clk = ~clk;

  ibex_rf_wb_arbiter #(.RV32E(1'b0), .DataWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_addr_i(ex_addr), .ex_data_i(ex_data), .ex_ready_o(ex_ready),
    .lsu_valid_i(lsu_valid), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
    .reserve_i(reserve), .reserve_addr_i(reserve_addr), .flush_i(flush),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .hazard_a_o(hazard_a), .hazard_b_o(hazard_b),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .err_o(err)
  );

  ibex_rf_wb_arbiter #(.RV32E(1'b1), .DataWidth(32)) dut_e (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_addr_i(ex_addr), .ex_data_i(ex_data), .ex_ready_o(e_ex_ready),
    .lsu_valid_i(lsu_valid), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data), .lsu_ready_o(e_lsu_ready),
    .reserve_i(reserve), .reserve_addr_i(reserve_addr), .flush_i(flush),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .hazard_a_o(e_hazard_a), .hazard_b_o(e_hazard_b),
    .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata), .err_o(e_err)
  );

  function automatic void model_reset();
    m_last_ex = 1'b0;
    m_gex     = 1'b0;
    m_we      = 1'b0;
    m_waddr   = '0;
    m_wdata   = '0;
    m_err     = 1'b0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endfunction

  function automatic bit exp_ex_gnt();
    return ex_valid && (!lsu_valid || !m_last_ex);
  endfunction

  function automatic bit exp_lsu_gnt();
    return lsu_valid && !exp_ex_gnt();
  endfunction

  function automatic void idle_inputs();
    ex_valid = 0; lsu_valid = 0; reserve = 0; flush = 0;
  endfunction

  // Advance one clock edge, applying the writeback/scoreboard rules to the model.
  task automatic tick();
    bit          gex, glsu, rsv, fl;
    int unsigned a, ra;
    logic [31:0] d;
    gex  = exp_ex_gnt();
    glsu = exp_lsu_gnt();
    a    = gex ? int'(ex_addr) : int'(lsu_addr);
    d    = gex ? ex_data : lsu_data;
    rsv  = reserve;
    ra   = int'(reserve_addr);
    fl   = flush;
    @(posedge clk);
    m_gex = gex;
    m_we  = 1'b0;
    if (rsv && ra != 0 && m_pend[ra]) m_err = 1'b1;
    if (gex || glsu) begin
      m_last_ex = gex;
      if (a != 0) begin
        m_we     = 1'b1;
        m_waddr  = 5'(a);
        m_wdata  = d;
        m_pend[a] = 1'b0;
      end
    end
    if (rsv && ra != 0) m_pend[ra] = 1'b1;
    if (fl) foreach (m_pend[i]) m_pend[i] = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    ex_addr = '0; lsu_addr = '0; reserve_addr = '0; raddr_a = 5'd1; raddr_b = 5'd2;
    ex_data = '0; lsu_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    n_chk++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr got=%h exp=0", rf_waddr); end
    n_chk++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
    tick();
    n_chk++; if ({ex_ready, lsu_ready} !== 2'b00) begin n_fail++; $display("FAIL idle_ready got=%b exp=00", {ex_ready, lsu_ready}); end
    n_chk++; if ({hazard_a, hazard_b} !== 2'b00) begin n_fail++; $display("FAIL idle_hazard got=%b exp=00", {hazard_a, hazard_b}); end
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL idle_rf_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_back_to_back();
    ex_valid = 1; ex_addr = 5'd3; ex_data = 32'hAAAA_0003;
    lsu_valid = 1; lsu_addr = 5'd4; lsu_data = 32'hBBBB_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (ex_ready !== (i % 2 == 0)) begin n_fail++; $display("FAIL rr_ex_ready[%0d] got=%b exp=%b", i, ex_ready, (i % 2 == 0)); end
      n_chk++; if (lsu_ready !== (i % 2 == 1)) begin n_fail++; $display("FAIL rr_lsu_ready[%0d] got=%b exp=%b", i, lsu_ready, (i % 2 == 1)); end
      tick();
      n_chk++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL rr_rf_we[%0d] got=%b exp=1", i, rf_we); end
      n_chk++; if (rf_waddr !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin n_fail++; $display("FAIL rr_waddr[%0d] got=%0d exp=%0d", i, rf_waddr, (i % 2 == 0) ? 3 : 4); end
      n_chk++; if (rf_wdata !== ((i % 2 == 0) ? 32'hAAAA_0003 : 32'hBBBB_0004)) begin n_fail++; $display("FAIL rr_wdata[%0d] got=%h", i, rf_wdata); end
    end
    idle_inputs();
    tick();
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rr_end_rf_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_ex_only();
    ex_valid = 1; ex_addr = 5'd5; ex_data = 32'hDEAD_BEEF;
    #1;
    n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL ex_only_ready got=%b exp=1", ex_ready); end
    n_chk++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL ex_only_lsu_ready got=%b exp=0", lsu_ready); end
    tick();
    ex_valid = 0;
    n_chk++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL ex_only_we got=%b exp=1", rf_we); end
    n_chk++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL ex_only_waddr got=%0d exp=5", rf_waddr); end
    n_chk++; if (rf_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ex_only_wdata got=%h exp=deadbeef", rf_wdata); end
    tick();
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL ex_only_we_drop got=%b exp=0", rf_we); end
    n_chk++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL ex_only_waddr_hold got=%0d exp=5", rf_waddr); end
  endtask

  task automatic test_scoreboard();
    raddr_a = 5'd7;
    reserve = 1; reserve_addr = 5'd7;
    #1;
    n_chk++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL sb_no_bypass got=%b exp=0", hazard_a); end
    tick();
    reserve = 0;
    #1;
    n_chk++; if (hazard_a !== 1'b1) begin n_fail++; $display("FAIL sb_reserve got=%b exp=1", hazard_a); end
    lsu_valid = 1; lsu_addr = 5'd7; lsu_data = 32'h0000_0707;
    #1;
    n_chk++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL sb_lsu_ready got=%b exp=1", lsu_ready); end
    tick();
    lsu_valid = 0;
    #1;
    n_chk++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL sb_release got=%b exp=0", hazard_a); end
    n_chk++; if (rf_waddr !== 5'd7 || rf_we !== 1'b1) begin n_fail++; $display("FAIL sb_lsu_write got=%b/%0d exp=1/7", rf_we, rf_waddr); end
    ex_valid = 1; ex_addr = 5'd7; ex_data = 32'h7777_7777;
    reserve = 1; reserve_addr = 5'd7;
    tick();
    idle_inputs();
    #1;
    n_chk++; if (hazard_a !== 1'b1) begin n_fail++; $display("FAIL sb_reserve_wins got=%b exp=1", hazard_a); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL sb_no_err got=%b exp=0", err); end
    ex_valid = 1;
    tick();
    ex_valid = 0;
    #1;
    n_chk++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL sb_cleanup got=%b exp=0", hazard_a); end
  endtask

  task automatic test_err_flush();
    raddr_b = 5'd9; raddr_a = 5'd10;
    reserve = 1; reserve_addr = 5'd9;
    tick();
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_first got=%b exp=0", err); end
    n_chk++; if (hazard_b !== 1'b1) begin n_fail++; $display("FAIL err_hazard_b got=%b exp=1", hazard_b); end
    tick();
    reserve = 0;
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_double got=%b exp=1", err); end
    tick();
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", err); end
    flush = 1; reserve = 1; reserve_addr = 5'd10;
    tick();
    idle_inputs();
    #1;
    n_chk++; if (hazard_b !== 1'b0) begin n_fail++; $display("FAIL flush_clear got=%b exp=0", hazard_b); end
    n_chk++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL flush_over_reserve got=%b exp=0", hazard_a); end
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL flush_err_kept got=%b exp=1", err); end
  endtask

  task automatic test_x0();
    ex_valid = 1; ex_addr = 5'd0; ex_data = 32'h0BAD_0000;
    #1;
    n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got=%b exp=1", ex_ready); end
    tick();
    ex_valid = 0;
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_rv32e();
    ex_valid = 1; ex_addr = 5'h15; ex_data = 32'h1234_5678;
    #1;
    n_chk++; if (e_ex_ready !== 1'b1) begin n_fail++; $display("FAIL rv32e_ready got=%b exp=1", e_ex_ready); end
    tick();
    ex_valid = 0;
    n_chk++; if (e_rf_we !== 1'b1 || e_rf_waddr !== 5'h05) begin n_fail++; $display("FAIL rv32e_waddr got=%b/%h exp=1/05", e_rf_we, e_rf_waddr); end
    n_chk++; if (rf_waddr !== 5'h15) begin n_fail++; $display("FAIL rv32i_waddr got=%h exp=15", rf_waddr); end
  endtask

  task automatic test_random();
    idle_inputs();
    tick();
    for (int c = 0; c < 400; c++) begin
      if (!ex_valid || m_gex) begin
        ex_valid = ($urandom % 3) != 0; ex_addr = 5'($urandom % 8); ex_data = $urandom;
      end
      if (!lsu_valid || (!m_gex && lsu_valid)) begin
        lsu_valid = ($urandom % 3) != 0; lsu_addr = 5'($urandom % 8); lsu_data = $urandom;
      end
      reserve = ($urandom % 4) == 0; reserve_addr = 5'($urandom % 8);
      flush = ($urandom % 20) == 0;
      raddr_a = 5'($urandom % 8); raddr_b = 5'($urandom % 8);
      #1;
      n_chk++; if (ex_ready !== exp_ex_gnt()) begin n_fail++; $display("FAIL rnd_ex_ready[%0d] got=%b exp=%b", c, ex_ready, exp_ex_gnt()); end
      n_chk++; if (lsu_ready !== exp_lsu_gnt()) begin n_fail++; $display("FAIL rnd_lsu_ready[%0d] got=%b exp=%b", c, lsu_ready, exp_lsu_gnt()); end
      n_chk++; if (hazard_a !== m_pend[raddr_a]) begin n_fail++; $display("FAIL rnd_hazard_a[%0d] got=%b exp=%b", c, hazard_a, m_pend[raddr_a]); end
      n_chk++; if (hazard_b !== m_pend[raddr_b]) begin n_fail++; $display("FAIL rnd_hazard_b[%0d] got=%b exp=%b", c, hazard_b, m_pend[raddr_b]); end
      tick();
      n_chk++; if (rf_we !== m_we) begin n_fail++; $display("FAIL rnd_we[%0d] got=%b exp=%b", c, rf_we, m_we); end
      n_chk++; if (rf_waddr !== m_waddr) begin n_fail++; $display("FAIL rnd_waddr[%0d] got=%0d exp=%0d", c, rf_waddr, m_waddr); end
      n_chk++; if (rf_wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", c, rf_wdata, m_wdata); end
      n_chk++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d] got=%b exp=%b", c, err, m_err); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_write();
    ex_valid = 1; ex_addr = 5'd12; ex_data = 32'hCAFE_F00D;
    reserve = 1; reserve_addr = 5'd6; raddr_a = 5'd6;
    tick();
    idle_inputs();
    n_chk++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_we got=%b exp=1", rf_we); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we got=%b exp=0", rf_we); end
    n_chk++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_fail++; $display("FAIL midrst_addr_data got=%0d/%h exp=0/0", rf_waddr, rf_wdata); end
    n_chk++; if (hazard_a !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_sb got=%b/%b exp=0/0", hazard_a, err); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL midrst_after_we got=%b exp=0", rf_we); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ex_only();
    test_scoreboard();
    test_err_flush();
    test_x0();
    test_rv32e();
    test_random();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
